jtframe_bank_resp: RTL and testbench
====================================

JTFRAME_BANK_RESP -- requirements
Module: jtframe_bank_resp

Interface
REQ-001 Parameter AW, default 22: bank/prog address width in 16-bit words.
REQ-002 Parameter BURST, default 2: words returned per read (1..4).
REQ-003 Port clk  in  1  system clock; single clock domain.
REQ-004 Port rst_n  in  1  reset, synchronous, active-low.
REQ-005 Ports ba0_addr..ba3_addr  in  AW each; ba_rd  in  4  per-bank read request, held until acked.
REQ-006 Ports ba_ack, ba_dst, ba_dok, ba_rdy  out  4 each; data_read  out  16  shared read data.
REQ-007 Ports prog_addr in AW, prog_data in 16, prog_mask in 2 (active-low), prog_ba in 2, prog_we in 1, prog_rd in 1; prog_ack, prog_rdy out 1.
REQ-008 Ports mem_req, mem_we out 1; mem_addr out AW; mem_ba out 2; mem_din out 16; mem_mask out 2; mem_gnt in 1 (request accepted); mem_dv in 1 (read word valid); mem_dout in 16; mem_wdone in 1 (write complete).

Function
REQ-009 States IDLE, ISSUE, RDATA, WDONE; only IDLE samples new requests.
REQ-010 IDLE priority: prog_we, then prog_rd, then banks round-robin starting at last_served+1 mod 4.
REQ-011 On selection: latch address, bank index, op type; go ISSUE next cycle with mem_req=1.
REQ-012 ISSUE holds mem_req/mem_addr/mem_ba/mem_we/mem_din/mem_mask stable until mem_gnt; requester withdrawal after selection is ignored.
REQ-013 Cycle of mem_gnt: mem_req=0; pulse ba_ack[sel] or prog_ack for exactly that cycle; read -> RDATA, write -> WDONE.
REQ-014 Bank reads: mem_ba = bank index, mem_addr = baN_addr; prog ops: mem_ba = prog_ba, mem_addr = prog_addr.
REQ-015 RDATA: each mem_dv registers mem_dout into data_read; one cycle later ba_dok[sel]=1; ba_dst[sel]=1 on the first word only; ba_rdy[sel]=1 on word BURST only.
REQ-016 Read latency: mem_dv at cycle N -> data_read/dok valid at N+1; ba_rdy at N+1 of word BURST, state IDLE at N+1.
REQ-017 Prog read: same data path, prog_rdy pulsed with last word; ba_* stay 0.
REQ-018 WDONE: mem_wdone -> prog_rdy pulse next cycle, return IDLE.
REQ-019 last_served updated only when a bank read completes; prog ops do not move it.
REQ-020 mem_dv or mem_wdone outside RDATA/WDONE is ignored; no output toggles.
REQ-021 Word counter width 2 bits; wraps to 0 on completion.
REQ-022 New request may be selected in the IDLE cycle immediately after completion (back-to-back, no bubble beyond IDLE).
REQ-023 All ba_* and prog_* strobes are one-hot per cycle; never two banks flagged together.

Reset
REQ-024 rst_n=0 at a clock edge: state IDLE, last_served=3 (bank 0 first), counters 0, all outputs 0 including data_read, regardless of operation in progress.
REQ-025 Transaction aborted by reset is not resumed; requesters re-issue.

Structure
REQ-026 Package jtframe_bank_pkg holds state encoding, MAXBURST constant, and bank index type.
REQ-027 Sub-module jtframe_rr_arb4: 4-way round-robin picker, inputs req[3:0], last[1:0]; outputs valid, sel[1:0]; combinational.

Verification
REQ-028 ba_rd=4'b0001, ba0_addr=0x1234, gnt 2 cycles later, dv words 0xAAAA,0xBBBB -> ack[0] 1 pulse, dst with 0xAAAA, rdy with 0xBBBB, mem_ba=0.
REQ-029 ba_rd=4'b1111 held, each served in sequence -> ack order 0,1,2,3,0.
REQ-030 prog_we addr 0x10 data 0x55AA mask 2'b10 while ba_rd[2]=1 -> write issued first, prog_ack, prog_rdy after wdone, then bank 2 served.
REQ-031 rst_n=0 after first of two dv words -> all outputs 0 next cycle, IDLE; second dv ignored.
REQ-032 Spurious mem_dv in IDLE with data 0xDEAD -> data_read and ba_dok unchanged.
REQ-033 mem_gnt delayed 10 cycles, ba_rd[1] dropped meanwhile -> mem_addr stable, ack[1] still pulses, burst completes.

Source files
------------

// File: rtl/jtframe_bank_pkg.sv
// +-----------------------------------------------------------------------+
// | jtframe_bank_pkg: shared types for the bank response controller       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package jtframe_bank_pkg;

  localparam int MAXBURST = 4;

  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2,
    ST_WDONE = 2'd3
  } state_t;

  function automatic logic [3:0] bank_onehot(input bank_t b);
    bank_onehot = 4'b0001 << b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_rr_arb4.sv
// +-----------------------------------------------------------------------+
// | jtframe_rr_arb4: combinational 4-way round-robin picker               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module jtframe_rr_arb4
  import jtframe_bank_pkg::*;
(
  input  logic [3:0] req,
  input  bank_t      last,
  output logic       valid,
  output bank_t      sel
);

  bank_t idx;

  // Scan from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    sel   = last;
    idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = last + bank_t'(i + 1);
      if (req[idx]) begin
        valid = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtframe_bank_resp.sv
// +-----------------------------------------------------------------------+
// | jtframe_bank_resp: arbitrates 4 bank readers and a prog port onto one |
// | memory request channel and returns burst read data. Rev 1.0           |
// +-----------------------------------------------------------------------+
`default_nettype none

module jtframe_bank_resp
  import jtframe_bank_pkg::*;
#(
  parameter int AW    = 22,
  parameter int BURST = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_rd,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_dst,
  output logic [3:0]    ba_dok,
  output logic [3:0]    ba_rdy,
  output logic [15:0]   data_read,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  input  logic [1:0]    prog_ba,
  input  logic          prog_we,
  input  logic          prog_rd,
  output logic          prog_ack,
  output logic          prog_rdy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_ba,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_mask,
  input  logic          mem_gnt,
  input  logic          mem_dv,
  input  logic [15:0]   mem_dout,
  input  logic          mem_wdone
);

  localparam logic [1:0] LASTW = 2'(BURST - 1);

  state_t        state_q, state_d;
  bank_t         last_q, sel_q;
  logic          prog_q, we_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    ba_q, mask_q, cnt_q;
  logic [15:0]   din_q, data_q;
  logic [3:0]    dok_q, dst_q, rdy_q;
  logic          prdy_q;

  logic          arb_valid;
  bank_t         arb_sel;
  logic          w_prog, w_start, w_lastw;
  logic [AW-1:0] w_ba_addr [4];

  assign w_ba_addr[0] = ba0_addr;
  assign w_ba_addr[1] = ba1_addr;
  assign w_ba_addr[2] = ba2_addr;
  assign w_ba_addr[3] = ba3_addr;

  jtframe_rr_arb4 u_arb (
    .req   (ba_rd),
    .last  (last_q),
    .valid (arb_valid),
    .sel   (arb_sel)
  );

  assign w_prog  = prog_we | prog_rd;
  assign w_start = w_prog | arb_valid;
  assign w_lastw = (cnt_q == LASTW);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (w_start) state_d = ST_ISSUE;
      ST_ISSUE: if (mem_gnt) state_d = we_q ? ST_WDONE : ST_RDATA;
      ST_RDATA: if (mem_dv && w_lastw) state_d = ST_IDLE;
      ST_WDONE: if (mem_wdone) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request drops and the ack fires in the same cycle the memory accepts.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ba_ack   = '0;
    prog_ack = 1'b0;
    if (state_q == ST_ISSUE) begin
      mem_we = we_q;
      if (mem_gnt) begin
        if (prog_q) prog_ack = 1'b1;
        else        ba_ack   = bank_onehot(sel_q);
      end else begin
        mem_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 2'd3;
      sel_q  <= '0;
      prog_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      ba_q   <= '0;
      mask_q <= '0;
      din_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      dok_q  <= '0;
      dst_q  <= '0;
      rdy_q  <= '0;
      prdy_q <= 1'b0;
    end else begin
      dok_q  <= '0;
      dst_q  <= '0;
      rdy_q  <= '0;
      prdy_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (w_prog) begin
            prog_q <= 1'b1;
            we_q   <= prog_we;
            addr_q <= prog_addr;
            ba_q   <= prog_ba;
            din_q  <= prog_we ? prog_data : 16'h0;
            mask_q <= prog_we ? prog_mask : 2'b00;
          end else if (arb_valid) begin
            prog_q <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= arb_sel;
            addr_q <= w_ba_addr[arb_sel];
            ba_q   <= arb_sel;
            din_q  <= 16'h0;
            mask_q <= 2'b00;
          end
          cnt_q <= '0;
        end
        ST_RDATA: begin
          if (mem_dv) begin
            data_q <= mem_dout;
            cnt_q  <= w_lastw ? 2'd0 : cnt_q + 2'd1;
            if (prog_q) begin
              prdy_q <= w_lastw;
            end else begin
              dok_q <= bank_onehot(sel_q);
              if (cnt_q == 2'd0) dst_q <= bank_onehot(sel_q);
              if (w_lastw) begin
                rdy_q  <= bank_onehot(sel_q);
                last_q <= sel_q;
              end
            end
          end
        end
        ST_WDONE: if (mem_wdone) prdy_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_ba    = ba_q;
  assign mem_din   = din_q;
  assign mem_mask  = mask_q;
  assign data_read = data_q;
  assign ba_dok    = dok_q;
  assign ba_dst    = dst_q;
  assign ba_rdy    = rdy_q;
  assign prog_rdy  = prdy_q;

endmodule

`default_nettype wire

// File: tb/tb_jtframe_bank_resp.sv
// +-----------------------------------------------------------------------+
// | tb_jtframe_bank_resp: directed self-checking bench for the controller |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_jtframe_bank_resp;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]    ba_rd;
  logic [3:0]    ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0]   data_read;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask, prog_ba;
  logic          prog_we, prog_rd, prog_ack, prog_rdy;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_ba, mem_mask;
  logic [15:0]   mem_din, mem_dout;
  logic          mem_gnt, mem_dv, mem_wdone;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtframe_bank_resp #(.AW(AW), .BURST(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ba0_addr  (ba0_addr),
    .ba1_addr  (ba1_addr),
    .ba2_addr  (ba2_addr),
    .ba3_addr  (ba3_addr),
    .ba_rd     (ba_rd),
    .ba_ack    (ba_ack),
    .ba_dst    (ba_dst),
    .ba_dok    (ba_dok),
    .ba_rdy    (ba_rdy),
    .data_read (data_read),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_mask (prog_mask),
    .prog_ba   (prog_ba),
    .prog_we   (prog_we),
    .prog_rd   (prog_rd),
    .prog_ack  (prog_ack),
    .prog_rdy  (prog_rdy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_ba    (mem_ba),
    .mem_din   (mem_din),
    .mem_mask  (mem_mask),
    .mem_gnt   (mem_gnt),
    .mem_dv    (mem_dv),
    .mem_dout  (mem_dout),
    .mem_wdone (mem_wdone)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: requester drops after ack, 1: holds, 2: withdraws while waiting for grant
  task automatic do_read(input int bank, input logic [AW-1:0] addr, input int gdly,
                         input int mode, input logic [15:0] w0, input logic [15:0] w1);
    logic [3:0] oh;
    oh = 4'(1 << bank);
    tick();
    for (int i = 0; i < gdly; i++) begin
      chk("wait_req",  32'(mem_req),  32'd1);
      chk("wait_addr", 32'(mem_addr), 32'(addr));
      chk("wait_ack",  32'(ba_ack),   32'd0);
      if (mode == 2) ba_rd[bank] = 1'b0;
      tick();
    end
    chk("issue_req",  32'(mem_req),  32'd1);
    chk("issue_addr", 32'(mem_addr), 32'(addr));
    chk("issue_ba",   32'(mem_ba),   32'(bank));
    chk("issue_we",   32'(mem_we),   32'd0);
    mem_gnt = 1'b1;
    #1;
    chk("gnt_ack",    32'(ba_ack),   32'(oh));
    chk("gnt_req",    32'(mem_req),  32'd0);
    chk("gnt_pack",   32'(prog_ack), 32'd0);
    if (mode == 0) ba_rd[bank] = 1'b0;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("post_ack", 32'(ba_ack), 32'd0);
    mem_dv   = 1'b1;
    mem_dout = w0;
    tick();
    chk("w0_data", 32'(data_read), 32'(w0));
    chk("w0_dok",  32'(ba_dok),    32'(oh));
    chk("w0_dst",  32'(ba_dst),    32'(oh));
    chk("w0_rdy",  32'(ba_rdy),    32'd0);
    mem_dout = w1;
    tick();
    chk("w1_data", 32'(data_read), 32'(w1));
    chk("w1_dok",  32'(ba_dok),    32'(oh));
    chk("w1_dst",  32'(ba_dst),    32'd0);
    chk("w1_rdy",  32'(ba_rdy),    32'(oh));
    mem_dv = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ba0_addr = 22'h1234; ba1_addr = 22'h0111; ba2_addr = 22'h0222; ba3_addr = 22'h0333;
    ba_rd = '0;
    prog_addr = '0; prog_data = '0; prog_mask = '0; prog_ba = '0;
    prog_we = 1'b0; prog_rd = 1'b0;
    mem_gnt = 1'b0; mem_dv = 1'b0; mem_dout = '0; mem_wdone = 1'b0;
    tick();
    tick();
    chk("rst_req",  32'(mem_req),   32'd0);
    chk("rst_data", 32'(data_read), 32'd0);
    chk("rst_ack",  32'(ba_ack),    32'd0);
    chk("rst_prdy", 32'(prog_rdy),  32'd0);
    chk("rst_addr", 32'(mem_addr),  32'd0);
    rst_n = 1'b1;
    tick();

    // Single bank 0 read, grant after two waiting cycles
    ba_rd = 4'b0001;
    do_read(0, 22'h1234, 2, 0, 16'hAAAA, 16'hBBBB);

    // Spurious data valid while idle
    mem_dv = 1'b1; mem_dout = 16'hDEAD;
    tick();
    chk("spur_data", 32'(data_read), 32'h0000BBBB);
    chk("spur_dok",  32'(ba_dok),    32'd0);
    mem_dv = 1'b0;

    // Prog write has priority over a pending bank 2 read
    prog_we = 1'b1; prog_addr = 22'h10; prog_data = 16'h55AA; prog_mask = 2'b10; prog_ba = 2'd1;
    ba_rd = 4'b0100;
    tick();
    chk("pw_req",  32'(mem_req),  32'd1);
    chk("pw_we",   32'(mem_we),   32'd1);
    chk("pw_addr", 32'(mem_addr), 32'h10);
    chk("pw_din",  32'(mem_din),  32'h55AA);
    chk("pw_mask", 32'(mem_mask), 32'd2);
    chk("pw_ba",   32'(mem_ba),   32'd1);
    mem_gnt = 1'b1;
    #1;
    chk("pw_pack", 32'(prog_ack), 32'd1);
    chk("pw_back", 32'(ba_ack),   32'd0);
    prog_we = 1'b0;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("pw_pack_off", 32'(prog_ack), 32'd0);
    chk("pw_wait_req", 32'(mem_req),  32'd0);
    chk("pw_wait_rdy", 32'(prog_rdy), 32'd0);
    mem_wdone = 1'b1;
    tick();
    chk("pw_prdy", 32'(prog_rdy), 32'd1);
    mem_wdone = 1'b0;
    do_read(2, 22'h0222, 0, 0, 16'h1111, 16'h2222);

    // Prog read: shared data path, only prog_rdy flags completion
    prog_rd = 1'b1; prog_addr = 22'h20; prog_ba = 2'd3;
    tick();
    chk("pr_addr", 32'(mem_addr), 32'h20);
    chk("pr_ba",   32'(mem_ba),   32'd3);
    chk("pr_we",   32'(mem_we),   32'd0);
    mem_gnt = 1'b1;
    #1;
    chk("pr_pack", 32'(prog_ack), 32'd1);
    chk("pr_back", 32'(ba_ack),   32'd0);
    prog_rd = 1'b0;
    tick();
    mem_gnt = 1'b0; mem_dv = 1'b1; mem_dout = 16'h7777;
    tick();
    chk("pr_w0",   32'(data_read), 32'h7777);
    chk("pr_dok",  32'(ba_dok),    32'd0);
    chk("pr_rdy0", 32'(prog_rdy),  32'd0);
    mem_dout = 16'h8888;
    tick();
    chk("pr_w1",   32'(data_read), 32'h8888);
    chk("pr_rdy1", 32'(prog_rdy),  32'd1);
    chk("pr_brdy", 32'(ba_rdy),    32'd0);
    mem_dv = 1'b0;
    tick();
    chk("pr_rdy_off", 32'(prog_rdy), 32'd0);

    // Reset in the middle of a burst
    ba_rd = 4'b0010;
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("ab_ack", 32'(ba_ack), 32'd2);
    ba_rd = 4'b0000;
    tick();
    mem_gnt = 1'b0; mem_dv = 1'b1; mem_dout = 16'hAAAA;
    tick();
    chk("ab_w0",  32'(data_read), 32'hAAAA);
    chk("ab_dok", 32'(ba_dok),    32'd2);
    rst_n = 1'b0; mem_dout = 16'hBBBB;
    tick();
    chk("ab_data", 32'(data_read), 32'd0);
    chk("ab_dok0", 32'(ba_dok),    32'd0);
    chk("ab_dst0", 32'(ba_dst),    32'd0);
    chk("ab_req0", 32'(mem_req),   32'd0);
    chk("ab_addr", 32'(mem_addr),  32'd0);
    rst_n = 1'b1;
    tick();
    chk("ab_ign_data", 32'(data_read), 32'd0);
    chk("ab_ign_rdy",  32'(ba_rdy),    32'd0);
    chk("ab_ign_dok",  32'(ba_dok),    32'd0);
    mem_dv = 1'b0;

    // All banks held: round-robin order 0,1,2,3,0 back to back
    ba_rd = 4'b1111;
    do_read(0, 22'h1234, 0, 1, 16'h0A00, 16'h0A01);
    do_read(1, 22'h0111, 0, 1, 16'h1A00, 16'h1A01);
    do_read(2, 22'h0222, 0, 1, 16'h2A00, 16'h2A01);
    do_read(3, 22'h0333, 0, 1, 16'h3A00, 16'h3A01);
    do_read(0, 22'h1234, 0, 1, 16'h4A00, 16'h4A01);
    ba_rd = 4'b0000;

    // Long grant delay with the requester withdrawing meanwhile
    ba_rd = 4'b0010;
    do_read(1, 22'h0111, 10, 2, 16'hC0DE, 16'hBEEF);
    tick();
    chk("end_req", 32'(mem_req), 32'd0);
    chk("end_rdy", 32'(ba_rdy),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
